// File: rtl/bpu_btb_bht_pkg.sv
// Shared CPU definitions: branch type codes, branch-result and prediction records.
package bpu_btb_bht_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 16;

  localparam logic [1:0] BIsNone = 2'd0;
  localparam logic [1:0] BIsImme = 2'd1;
  localparam logic [1:0] BIsCall = 2'd2;
  localparam logic [1:0] BIsRetn = 2'd3;

  // Resolved-branch record returned from EXE
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [1:0]      br_type;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [1:0]      count;
    logic            hit;
    logic            retn_success;
  } BResult;

  // Prediction handed to IF
  typedef struct packed {
    logic            valid;
    logic            hit;
    logic [1:0]      count;
    logic [XLEN-1:0] target;
    logic [1:0]      br_type;
  } PResult;

  // Two-bit saturating counter step
  function automatic logic [1:0] sat_count(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module bpu_ras #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top_c,
  output logic        empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [OCC_W-1:0] occ;

  // Pointer and occupancy; pop on empty is ignored, occupancy saturates on push
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
      occ <= '0;
    end else if (push) begin
      ptr <= PTR_W'(ptr + 1'b1);
      if (occ != OCC_W'(DEPTH)) occ <= OCC_W'(occ + 1'b1);
    end else if (pop && (occ != '0)) begin
      ptr <= PTR_W'(ptr - 1'b1);
      occ <= OCC_W'(occ - 1'b1);
    end
  end

  // Stack storage, written at the next-push slot
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  assign top_c   = mem[PTR_W'(ptr - 1'b1)];
  assign empty_c = (occ == '0);

endmodule

// File: rtl/bpu_btb_bht.sv
// Direct-mapped BTB with 2-bit counters, pipelined update with bypass, and RAS.
module bpu_btb_bht
  import bpu_btb_bht_pkg::*;
#(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_Req,
  input  logic        IF_Stall,
  input  logic [31:0] IF_PC,
  input  logic        Flush,
  input  BResult      EXE_BResult,
  output PResult      IF_PResult,
  output logic        IF_PredTaken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] tbl_valid;
  logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
  logic [XLEN-1:0]    tbl_target [ENTRIES];
  logic [1:0]         tbl_type   [ENTRIES];
  logic [1:0]         tbl_count  [ENTRIES];

  BResult           upd;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [1:0]       upd_count;
  logic             upd_push;
  logic             upd_pop;
  logic [XLEN-1:0]  ras_push_data;
  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             e_valid;
  logic [TAG_W-1:0] e_tag;
  logic [XLEN-1:0]  e_target;
  logic [1:0]       e_type;
  logic [1:0]       e_count;
  logic             lk_hit;
  logic             lk_taken;
  PResult           lk_pres;

  logic             unused_retn;

  assign upd_idx       = upd.pc[IDX_W+1:2];
  assign upd_tag       = upd.pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_count     = upd.hit ? sat_count(upd.count, upd.taken)
                                 : (upd.taken ? 2'b10 : 2'b01);
  assign upd_push      = upd.valid && (upd.br_type == BIsCall);
  assign upd_pop       = upd.valid && (upd.br_type == BIsRetn);
  assign ras_push_data = upd.pc + 32'd8;
  assign unused_retn   = upd.retn_success;

  assign lk_idx = IF_PC[IDX_W+1:2];
  assign lk_tag = IF_PC[IDX_W+TAG_W+1:IDX_W+2];

  // Update register: only real branches are kept, written to the table next edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      upd <= '0;
    end else if (EXE_BResult.valid && (EXE_BResult.br_type != BIsNone)) begin
      upd <= EXE_BResult;
    end else begin
      upd <= '0;
    end
  end

  // Entry valid bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tbl_valid <= '0;
    end else if (upd.valid) begin
      tbl_valid[upd_idx] <= 1'b1;
    end
  end

  // Entry payload; meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (upd.valid) begin
      tbl_tag[upd_idx]    <= upd_tag;
      tbl_target[upd_idx] <= upd.target;
      tbl_type[upd_idx]   <= upd.br_type;
      tbl_count[upd_idx]  <= upd_count;
    end
  end

  // Entry read with bypass from the write happening this cycle
  always_comb begin
    e_valid  = tbl_valid[lk_idx];
    e_tag    = tbl_tag[lk_idx];
    e_target = tbl_target[lk_idx];
    e_type   = tbl_type[lk_idx];
    e_count  = tbl_count[lk_idx];
    if (upd.valid && (upd_idx == lk_idx)) begin
      e_valid  = 1'b1;
      e_tag    = upd_tag;
      e_target = upd.target;
      e_type   = upd.br_type;
      e_count  = upd_count;
    end
  end

  // Hit, taken decision and predicted target
  always_comb begin
    lk_hit          = e_valid && (e_tag == lk_tag);
    lk_taken        = lk_hit && ((e_type == BIsCall) || (e_type == BIsRetn) || e_count[1]);
    lk_pres         = '0;
    lk_pres.valid   = 1'b1;
    lk_pres.hit     = lk_hit;
    lk_pres.count   = lk_hit ? e_count : 2'b01;
    lk_pres.br_type = lk_hit ? e_type : BIsNone;
    if (!lk_taken) begin
      lk_pres.target = IF_PC + 32'd8;
    end else if ((e_type == BIsRetn) && !ras_empty) begin
      lk_pres.target = ras_top;
    end else begin
      lk_pres.target = e_target;
    end
  end

  // Registered prediction: flush kills, stall holds, otherwise load or invalidate
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      IF_PResult   <= '0;
      IF_PredTaken <= 1'b0;
    end else if (Flush) begin
      IF_PResult   <= '0;
      IF_PredTaken <= 1'b0;
    end else if (!IF_Stall) begin
      if (IF_Req) begin
        IF_PResult   <= lk_pres;
        IF_PredTaken <= lk_taken;
      end else begin
        IF_PResult   <= '0;
        IF_PredTaken <= 1'b0;
      end
    end
  end

  bpu_ras #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .resetn    (resetn),
    .push      (upd_push),
    .pop       (upd_pop),
    .push_data (ras_push_data),
    .top_c     (ras_top),
    .empty_c   (ras_empty)
  );

endmodule

// File: tb/tb_bpu_btb_bht.sv
// Randomized + directed bench for bpu_btb_bht against a behavioural predictor model.
module tb_bpu_btb_bht;
  import bpu_btb_bht_pkg::*;

  localparam int unsigned ENT = 64;
  localparam int unsigned RD  = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req, stall, flush;
  logic [31:0] pc;
  BResult      br;
  PResult      IF_PResult;
  logic        IF_PredTaken;

  int n_chk = 0;
  int n_err = 0;

  // Model state: table contents as seen by the next lookup, RAS as a queue
  logic        m_valid  [ENT];
  logic [15:0] m_tag    [ENT];
  logic [31:0] m_target [ENT];
  logic [1:0]  m_type   [ENT];
  logic [1:0]  m_count  [ENT];
  logic [31:0] ras_q[$];
  int          pend_op;       // RAS effect of the update captured last edge: 0 none, 1 push, 2 pop
  logic [31:0] pend_val;
  PResult      exp_p;
  logic        exp_tk;

  bpu_btb_bht #(.ENTRIES(ENT), .RAS_DEPTH(RD)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .IF_Req       (req),
    .IF_Stall     (stall),
    .IF_PC        (pc),
    .Flush        (flush),
    .EXE_BResult  (br),
    .IF_PResult   (IF_PResult),
    .IF_PredTaken (IF_PredTaken)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] p);
    return int'((p >> 2) % ENT);
  endfunction

  function automatic logic [15:0] tag_of(input logic [31:0] p);
    return 16'(p >> 8);
  endfunction

  function automatic logic m_hit(input logic [31:0] p);
    return m_valid[idx_of(p)] && (m_tag[idx_of(p)] == tag_of(p));
  endfunction

  // Prediction from the model's table and stack
  task automatic mdl_predict(input logic [31:0] p, output PResult r, output logic tk);
    int i;
    logic h;
    i = idx_of(p);
    h = m_hit(p);
    r = '0;
    r.valid   = 1'b1;
    r.hit     = h;
    r.count   = h ? m_count[i] : 2'b01;
    r.br_type = h ? m_type[i] : BIsNone;
    tk = h && (m_type[i] == BIsCall || m_type[i] == BIsRetn || m_count[i] >= 2'd2);
    if (!tk) r.target = p + 32'd8;
    else if (m_type[i] == BIsRetn && ras_q.size() > 0) r.target = ras_q[$];
    else r.target = m_target[i];
  endtask

  // Build an EXE record whose Hit/Count reflect what was predicted for that PC
  function automatic BResult mk_upd(input logic [31:0] p, input logic [1:0] t,
                                    input logic tk, input logic [31:0] tgt);
    BResult b;
    b = '0;
    b.valid   = 1'b1;
    b.pc      = p;
    b.br_type = t;
    b.taken   = tk;
    b.target  = tgt;
    b.hit     = m_hit(p);
    b.count   = b.hit ? m_count[idx_of(p)] : 2'b01;
    return b;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
    ras_q.delete();
    pend_op = 0;
    pend_val = '0;
    exp_p = '0;
    exp_tk = 1'b0;
  endtask

  // One clock edge of the model
  task automatic mdl_edge();
    PResult r;
    logic tk;
    int i, c;
    if (flush) begin
      exp_p = '0; exp_tk = 1'b0;
    end else if (!stall) begin
      if (req) begin
        mdl_predict(pc, r, tk);
        exp_p = r; exp_tk = tk;
      end else begin
        exp_p = '0; exp_tk = 1'b0;
      end
    end
    if (pend_op == 1) begin
      if (ras_q.size() == RD) void'(ras_q.pop_front());
      ras_q.push_back(pend_val);
    end else if (pend_op == 2) begin
      if (ras_q.size() > 0) void'(ras_q.pop_back());
    end
    pend_op = 0;
    if (br.valid && br.br_type != BIsNone) begin
      i = idx_of(br.pc);
      if (br.hit) begin
        c = int'(br.count) + (br.taken ? 1 : -1);
        if (c > 3) c = 3;
        if (c < 0) c = 0;
      end else begin
        c = br.taken ? 2 : 1;
      end
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(br.pc);
      m_target[i] = br.target;
      m_type[i]   = br.br_type;
      m_count[i]  = 2'(c);
      if (br.br_type == BIsCall) begin pend_op = 1; pend_val = br.pc + 32'd8; end
      if (br.br_type == BIsRetn) pend_op = 2;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    mdl_edge();
    #1;
    check("valid", 64'(IF_PResult.valid), 64'(exp_p.valid));
    check("taken", 64'(IF_PredTaken), 64'(exp_tk));
    if (exp_p.valid) check("presult", 64'(IF_PResult), 64'(exp_p));
  endtask

  task automatic idle();
    req = 1'b0; stall = 1'b0; flush = 1'b0; pc = '0; br = '0;
  endtask

  task automatic apply_reset();
    idle();
    resetn = 1'b0;
    mdl_reset();
    #1;
    check("rst_presult", 64'(IF_PResult), 64'd0);
    check("rst_taken", 64'(IF_PredTaken), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  PResult saved;

  initial begin
    idle();
    #2;
    apply_reset();

    // Cold miss
    req = 1'b1; pc = 32'h1000;
    cycle();
    check("cold_hit", 64'(IF_PResult.hit), 64'd0);
    check("cold_count", 64'(IF_PResult.count), 64'd1);
    check("cold_target", 64'(IF_PResult.target), 64'h1008);
    check("cold_taken", 64'(IF_PredTaken), 64'd0);

    // Counter training to strongly taken, then one not-taken
    idle();
    for (int k = 0; k < 3; k++) begin
      br = mk_upd(32'h1000, BIsImme, 1'b1, 32'h2000);
      cycle();
    end
    br = '0; req = 1'b1; pc = 32'h1000;
    cycle();
    check("train_hit", 64'(IF_PResult.hit), 64'd1);
    check("train_count", 64'(IF_PResult.count), 64'd3);
    check("train_target", 64'(IF_PResult.target), 64'h2000);
    check("train_taken", 64'(IF_PredTaken), 64'd1);
    idle();
    br = mk_upd(32'h1000, BIsImme, 1'b0, 32'h2000);
    cycle();
    br = '0; req = 1'b1; pc = 32'h1000;
    cycle();
    check("untrain_count", 64'(IF_PResult.count), 64'd2);
    check("untrain_taken", 64'(IF_PredTaken), 64'd1);

    // Return target from the RAS, then from the entry once the RAS is empty
    idle();
    br = mk_upd(32'h4004, BIsRetn, 1'b1, 32'h5000); cycle();
    br = mk_upd(32'h3000, BIsCall, 1'b1, 32'h3100); cycle();
    br = '0; cycle();
    req = 1'b1; pc = 32'h4004; cycle();
    check("ret_ras_target", 64'(IF_PResult.target), 64'h3008);
    check("ret_ras_taken", 64'(IF_PredTaken), 64'd1);
    idle();
    br = mk_upd(32'h4004, BIsRetn, 1'b1, 32'h5000); cycle();
    br = '0; cycle();
    req = 1'b1; pc = 32'h4004; cycle();
    check("ret_empty_target", 64'(IF_PResult.target), 64'h5000);

    // Nine calls overflow the 8-deep stack, nine returns drain it
    idle();
    for (int k = 1; k <= 9; k++) begin
      br = mk_upd(32'(k * 32'h100), BIsCall, 1'b1, 32'h9000);
      cycle();
    end
    br = '0; cycle(); cycle();
    for (int k = 0; k < 9; k++) begin
      req = 1'b1; pc = 32'h4004; cycle();
      check("ras_pop", 64'(IF_PResult.target), (k < 8) ? 64'(32'h908 - 32'(k) * 32'h100) : 64'h5000);
      idle();
      br = mk_upd(32'h4004, BIsRetn, 1'b1, 32'h5000); cycle();
      br = '0; cycle();
    end
    req = 1'b1; pc = 32'h4004; cycle();
    check("ras_underflow", 64'(IF_PResult.target), 64'h5000);

    // Lookup of index 5 in the same cycle the table is written
    idle();
    br = mk_upd(32'h6014, BIsImme, 1'b1, 32'h7777_0000); cycle();
    br = '0; req = 1'b1; pc = 32'h6014; cycle();
    check("bypass_hit", 64'(IF_PResult.hit), 64'd1);
    check("bypass_target", 64'(IF_PResult.target), 64'h7777_0000);
    check("bypass_taken", 64'(IF_PredTaken), 64'd1);

    // Stall hold, flush kill
    idle();
    req = 1'b1; pc = 32'h6014; cycle();
    saved = exp_p;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      req = 1'($urandom);
      cycle();
      check("stall_hold", 64'(IF_PResult), 64'(saved));
    end
    stall = 1'b0; flush = 1'b1; req = 1'b1; pc = 32'h6014;
    cycle();
    check("flush_valid", 64'(IF_PResult.valid), 64'd0);
    check("flush_taken", 64'(IF_PredTaken), 64'd0);

    // Reset while an update is pending
    idle();
    br = mk_upd(32'h8008, BIsImme, 1'b1, 32'hABC0); cycle();
    apply_reset();
    req = 1'b1; pc = 32'h8008; cycle();
    check("rst_mid_hit", 64'(IF_PResult.hit), 64'd0);

    // Random traffic over a small PC set to create hits, aliasing and RAS activity
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rp;
      req   = ($urandom_range(0, 9) < 8);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 5);
      pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      rp    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 1) == 1)
        br = mk_upd(rp, 2'($urandom_range(0, 3)), 1'($urandom), $urandom & 32'hFFFF_FFFC);
      else
        br = '0;
      cycle();
    end

    idle();
    cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
